// File: rtl/tlp_rd_pkg.sv
// Shared definitions for the PCIe read-request path: MRRS decode, 4 KB
// boundary constant, descriptor field widths and splitter state encoding.
package tlp_rd_pkg;

    // Width of the PCIe TLP length field (1024 DW encodes as 0)
    localparam int unsigned TLP_LEN_WIDTH = 10;

    // Chunk arithmetic width: holds 1..1024 DW
    localparam int unsigned CHUNK_WIDTH = 11;

    // DW count between 4 KB boundaries
    localparam logic [CHUNK_WIDTH-1:0] BOUNDARY_DW = 11'd1024;

    // MRRS decode: 32 DW << n, codes above 5 clamp to 5 (4 KB)
    localparam logic [2:0]             MRRS_MAX_CODE = 3'd5;
    localparam logic [CHUNK_WIDTH-1:0] MRRS_BASE_DW  = 11'd32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } split_state_t;

    function automatic logic [CHUNK_WIDTH-1:0] mrrs_to_dw(input logic [2:0] code);
        logic [2:0] n;
        n = (code > MRRS_MAX_CODE) ? MRRS_MAX_CODE : code;
        return MRRS_BASE_DW << n;
    endfunction

endpackage

// File: rtl/tlp_tag_pool.sv
// Tag pool: busy vector, lowest-free selection, outstanding counter and
// the sticky error for releasing a tag that is not busy.
module tlp_tag_pool #(
    parameter int unsigned C_TAG_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_alloc,
    input  logic [C_TAG_WIDTH-1:0] i_alloc_tag,
    input  logic                   i_free_valid,
    input  logic [C_TAG_WIDTH-1:0] i_free_tag,
    output logic                   o_avail_next,
    output logic [C_TAG_WIDTH-1:0] o_free_tag_next,
    output logic [C_TAG_WIDTH:0]   o_outstanding,
    output logic                   o_err_free
);

    localparam int unsigned NTAGS = 2**C_TAG_WIDTH;

    logic [NTAGS-1:0]       r_busy;
    logic [C_TAG_WIDTH:0]   r_outstanding;
    logic                   r_err_free;
    logic                   w_free_hit;
    logic [NTAGS-1:0]       w_busy_next;
    logic                   w_avail;
    logic [C_TAG_WIDTH-1:0] w_free_tag;

    // Busy vector as it will be after this cycle's free and allocate
    always_comb begin
        w_free_hit  = i_free_valid & r_busy[i_free_tag];
        w_busy_next = r_busy;
        if (w_free_hit) begin
            w_busy_next[i_free_tag] = 1'b0;
        end
        if (i_alloc) begin
            w_busy_next[i_alloc_tag] = 1'b1;
        end
    end

    // Lowest free tag of the post-update vector, so a tag freed now is usable next cycle
    always_comb begin
        w_avail    = 1'b0;
        w_free_tag = '0;
        for (int unsigned i = 0; i < NTAGS; i++) begin
            if (!w_avail && !w_busy_next[i]) begin
                w_avail    = 1'b1;
                w_free_tag = C_TAG_WIDTH'(i);
            end
        end
    end

    // Busy vector, up/down outstanding counter and sticky bad-free flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= '0;
            r_outstanding <= '0;
            r_err_free    <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            case ({i_alloc, w_free_hit})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (i_free_valid && !r_busy[i_free_tag]) begin
                r_err_free <= 1'b1;
            end
        end
    end

    assign o_avail_next    = w_avail;
    assign o_free_tag_next = w_free_tag;
    assign o_outstanding   = r_outstanding;
    assign o_err_free      = r_err_free;

endmodule

// File: rtl/tlp_rd_req_split.sv
// Read request splitter: cuts DW-aligned read requests into Memory Read
// descriptors bounded by MRRS and 4 KB, each carrying a pool tag.
module tlp_rd_req_split
    import tlp_rd_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_TAG_WIDTH  = 5,
    parameter int unsigned C_LEN_WIDTH  = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [C_ADDR_WIDTH-1:0]  req_addr,
    input  logic [C_LEN_WIDTH-1:0]   req_len_dw,
    input  logic [2:0]               cfg_mrrs,
    output logic                     tlp_valid,
    input  logic                     tlp_ready,
    output logic [C_ADDR_WIDTH-1:0]  tlp_addr,
    output logic [TLP_LEN_WIDTH-1:0] tlp_len_dw,
    output logic [C_TAG_WIDTH-1:0]   tlp_tag,
    output logic                     tlp_last,
    input  logic                     tag_free_valid,
    input  logic [C_TAG_WIDTH-1:0]   tag_free,
    output logic [C_TAG_WIDTH:0]     outstanding,
    output logic [1:0]               err
);

    split_state_t r_state, w_state_nxt;

    // cur_addr/rem track the first DW not yet placed in a descriptor register
    logic [C_ADDR_WIDTH-1:0]  r_cur_addr;
    logic [C_LEN_WIDTH-1:0]   r_rem;
    logic [CHUNK_WIDTH-1:0]   r_mrrs_dw;
    logic                     r_tlp_valid;
    logic [C_ADDR_WIDTH-1:0]  r_tlp_addr;
    logic [TLP_LEN_WIDTH-1:0] r_tlp_len;
    logic [C_TAG_WIDTH-1:0]   r_tlp_tag;
    logic                     r_tlp_last;
    logic                     r_err_zero;

    logic                     w_hs;
    logic                     w_accept;
    logic                     w_zero_len;
    logic                     w_load;
    logic                     w_req_ready;
    logic [CHUNK_WIDTH-1:0]   w_rem_ext;
    logic [CHUNK_WIDTH-1:0]   w_bound;
    logic [CHUNK_WIDTH-1:0]   w_chunk;
    logic                     w_avail_next;
    logic [C_TAG_WIDTH-1:0]   w_free_tag_next;
    logic                     w_err_free;

    assign w_hs = r_tlp_valid & tlp_ready;

    // Chunk = min(remaining, MRRS, DW left before the next 4 KB boundary)
    always_comb begin
        w_rem_ext = CHUNK_WIDTH'(r_rem);
        w_bound   = BOUNDARY_DW - {1'b0, r_cur_addr[11:2]};
        w_chunk   = w_rem_ext;
        if (r_mrrs_dw < w_chunk) begin
            w_chunk = r_mrrs_dw;
        end
        if (w_bound < w_chunk) begin
            w_chunk = w_bound;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control strobes; the next descriptor is loaded on the
    // handshake edge of the current one so issue runs at one per cycle
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_accept    = 1'b0;
        w_zero_len  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    if (req_len_dw == '0) begin
                        w_zero_len = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_SPLIT;
                    end
                end
            end
            ST_SPLIT: begin
                if (w_hs && r_tlp_last) begin
                    w_state_nxt = ST_IDLE;
                end else if ((!r_tlp_valid || w_hs) && (r_rem != '0) && w_avail_next) begin
                    w_load = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, descriptor registers and zero-length error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr  <= '0;
            r_rem       <= '0;
            r_mrrs_dw   <= '0;
            r_tlp_valid <= 1'b0;
            r_tlp_addr  <= '0;
            r_tlp_len   <= '0;
            r_tlp_tag   <= '0;
            r_tlp_last  <= 1'b0;
            r_err_zero  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur_addr <= req_addr;
                r_rem      <= req_len_dw;
                r_mrrs_dw  <= mrrs_to_dw(cfg_mrrs);
            end
            if (w_load) begin
                r_tlp_valid <= 1'b1;
                r_tlp_addr  <= r_cur_addr;
                r_tlp_len   <= w_chunk[TLP_LEN_WIDTH-1:0];
                r_tlp_tag   <= w_free_tag_next;
                r_tlp_last  <= (w_rem_ext == w_chunk);
                r_cur_addr  <= r_cur_addr + C_ADDR_WIDTH'({w_chunk, 2'b00});
                r_rem       <= r_rem - C_LEN_WIDTH'(w_chunk);
            end else if (w_hs) begin
                r_tlp_valid <= 1'b0;
            end
            if (w_zero_len) begin
                r_err_zero <= 1'b1;
            end
        end
    end

    tlp_tag_pool #(
        .C_TAG_WIDTH (C_TAG_WIDTH)
    ) u_tag_pool (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_alloc         (w_hs),
        .i_alloc_tag     (r_tlp_tag),
        .i_free_valid    (tag_free_valid),
        .i_free_tag      (tag_free),
        .o_avail_next    (w_avail_next),
        .o_free_tag_next (w_free_tag_next),
        .o_outstanding   (outstanding),
        .o_err_free      (w_err_free)
    );

    assign req_ready  = w_req_ready;
    assign tlp_valid  = r_tlp_valid;
    assign tlp_addr   = r_tlp_addr;
    assign tlp_len_dw = r_tlp_len;
    assign tlp_tag    = r_tlp_tag;
    assign tlp_last   = r_tlp_last;
    assign err        = {w_err_free, r_err_zero};

endmodule

// File: tb/tb_tlp_rd_req_split.sv
// Scoreboard bench for tlp_rd_req_split: the monitor turns every accepted
// request into its expected descriptor list and checks each descriptor.
module tb_tlp_rd_req_split;

    localparam int unsigned AW = 64;
    localparam int unsigned TW = 5;
    localparam int unsigned LW = 11;
    localparam int unsigned NT = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len_dw = '0;
    logic [2:0]    cfg_mrrs = '0;
    logic          tlp_valid;
    logic          tlp_ready = 1'b1;
    logic [AW-1:0] tlp_addr;
    logic [9:0]    tlp_len_dw;
    logic [TW-1:0] tlp_tag;
    logic          tlp_last;
    logic          tag_free_valid = 1'b0;
    logic [TW-1:0] tag_free = '0;
    logic [TW:0]   outstanding;
    logic [1:0]    err;

    always #5 clk = ~clk;

    tlp_rd_req_split #(
        .C_ADDR_WIDTH (AW),
        .C_TAG_WIDTH  (TW),
        .C_LEN_WIDTH  (LW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_len_dw     (req_len_dw),
        .cfg_mrrs       (cfg_mrrs),
        .tlp_valid      (tlp_valid),
        .tlp_ready      (tlp_ready),
        .tlp_addr       (tlp_addr),
        .tlp_len_dw     (tlp_len_dw),
        .tlp_tag        (tlp_tag),
        .tlp_last       (tlp_last),
        .tag_free_valid (tag_free_valid),
        .tag_free       (tag_free),
        .outstanding    (outstanding),
        .err            (err)
    );

    typedef struct {
        logic [63:0] addr;
        logic [9:0]  len;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [NT-1:0] m_busy = '0;
    logic [1:0]  m_err = '0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        prev_hold = 1'b0;
    int          cur_tag = 0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_free(input logic [NT-1:0] b);
        for (int i = 0; i < NT; i++) if (!b[i]) return i;
        return -1;
    endfunction

    function automatic int popcnt(input logic [NT-1:0] b);
        int c = 0;
        for (int i = 0; i < NT; i++) c += int'(b[i]);
        return c;
    endfunction

    // Reference split: walk the request, each piece limited by remaining, MRRS and 4 KB
    function automatic void model_req(input logic [63:0] a0, input logic [10:0] l, input logic [2:0] cfg);
        logic [63:0] a;
        int unsigned r, mrrs, room, c;
        exp_t e;
        if (l == 0) begin
            m_err[0] = 1'b1;
            return;
        end
        mrrs = 32 << ((cfg > 5) ? 5 : cfg);
        a = a0;
        r = l;
        while (r > 0) begin
            room = 1024 - (int'(a % 64'd4096) / 4);
            c = r;
            if (mrrs < c) c = mrrs;
            if (room < c) c = room;
            e.addr = a;
            e.len  = 10'(c % 1024);
            e.last = (r == c);
            exp_q.push_back(e);
            a = a + 64'(c) * 64'd4;
            r = r - c;
        end
    endfunction

    // Monitor: checks presented descriptors and maintains the tag/err model
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_busy    = '0;
            m_err     = '0;
            prev_hold = 1'b0;
        end else begin
            check("outstanding", 64'(outstanding), 64'(popcnt(m_busy)));
            if (prev_hold) check("valid_held", 64'(tlp_valid), 64'd1);
            if (tlp_valid) begin
                if (!prev_hold) begin
                    cur_tag = lowest_free(m_busy);
                    check("tag_lowest", 64'(tlp_tag), 64'(cur_tag));
                end else begin
                    check("tag_stable", 64'(tlp_tag), 64'(cur_tag));
                end
                if (exp_q.size() == 0) begin
                    check("desc_expected", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q[0];
                    check("desc_addr", tlp_addr, mon_e.addr);
                    check("desc_len", 64'(tlp_len_dw), 64'(mon_e.len));
                    check("desc_last", 64'(tlp_last), 64'(mon_e.last));
                end
                if (tlp_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    m_busy[tlp_tag] = 1'b1;
                end
            end
            prev_hold = tlp_valid && !tlp_ready;
            if (tag_free_valid) begin
                if (m_busy[tag_free]) m_busy[tag_free] = 1'b0;
                else m_err[1] = 1'b1;
            end
            if (req_valid && req_ready) model_req(req_addr, req_len_dw, cfg_mrrs);
        end
    end

    task automatic send_req(input logic [63:0] a, input logic [10:0] l);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_addr   = a;
        req_len_dw = l;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        check("req_accept", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && req_ready && !tlp_valid) break;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pick_busy(output logic v, output logic [TW-1:0] t);
        int lst[$];
        for (int i = 0; i < NT; i++) if (m_busy[i]) lst.push_back(i);
        v = (lst.size() > 0);
        t = v ? TW'(lst[$urandom_range(0, lst.size() - 1)]) : '0;
    endtask

    task automatic free_all();
        for (int i = 0; i < NT; i++) begin
            if (m_busy[i]) begin
                @(posedge clk); #1;
                tag_free_valid = 1'b1;
                tag_free       = TW'(i);
            end
        end
        @(posedge clk); #1;
        tag_free_valid = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hs, fv;
        logic [TW-1:0] ft;
        int nreq;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_tlp_valid", 64'(tlp_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MRRS 512 B split with latency check
        cfg_mrrs = 3'd2;
        send_req(64'h1000, 11'd256);
        check("lat_cycle1_valid", 64'(tlp_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_cycle2_valid", 64'(tlp_valid), 64'd1);
        check("t1_addr", tlp_addr, 64'h1000);
        check("t1_len", 64'(tlp_len_dw), 64'd128);
        check("t1_tag", 64'(tlp_tag), 64'd0);
        check("t1_last", 64'(tlp_last), 64'd0);
        wait_idle();
        check("t1_outstanding", 64'(outstanding), 64'd2);
        free_all();

        // 4 KB boundary crossing and full 4 KB request
        cfg_mrrs = 3'd5;
        send_req(64'h1F80, 11'd64);
        wait_idle();
        send_req(64'h3000, 11'd1024);
        wait_idle();
        free_all();

        // Tag exhaustion then release of tag 7
        cfg_mrrs = 3'd0;
        for (int i = 0; i < 32; i++) send_req(64'h8000 + 64'(i) * 4, 11'd1);
        wait_idle();
        check("full_outstanding", 64'(outstanding), 64'd32);
        send_req(64'h9000, 11'd1);
        repeat (6) @(posedge clk);
        #1;
        check("exhaust_valid", 64'(tlp_valid), 64'd0);
        @(posedge clk); #1;
        tag_free_valid = 1'b1;
        tag_free       = 5'd7;
        @(posedge clk); #1;
        tag_free_valid = 1'b0;
        check("resume_valid", 64'(tlp_valid), 64'd1);
        check("resume_tag", 64'(tlp_tag), 64'd7);
        @(posedge clk); #1;
        check("resume_outstanding", 64'(outstanding), 64'd32);
        wait_idle();
        free_all();

        // Backpressure mid-request
        send_req(64'h0, 11'd256);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tlp_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tlp_ready = 1'b1;
        wait_idle();
        check("bp_outstanding", 64'(outstanding), 64'd8);
        free_all();

        // Error flags
        send_req(64'h100, 11'd0);
        @(posedge clk); #1;
        check("zero_len_err", 64'(err), 64'd1);
        check("zero_len_no_desc", 64'(tlp_valid), 64'd0);
        tag_free_valid = 1'b1;
        tag_free       = 5'd3;
        @(posedge clk); #1;
        tag_free_valid = 1'b0;
        check("bad_free_err", 64'(err), 64'd3);
        check("bad_free_outstanding", 64'(outstanding), 64'd0);

        // Randomized traffic with random backpressure, MRRS changes and frees
        nreq = 0;
        for (int cyc = 0; cyc < 20000 && nreq < 60; cyc++) begin
            @(negedge clk);
            hs = req_valid && req_ready;
            @(posedge clk); #1;
            if (hs) begin
                req_valid = 1'b0;
                nreq++;
            end
            if (!req_valid && $urandom_range(0, 3) == 0) begin
                req_valid  = 1'b1;
                req_addr   = {$urandom(), $urandom()} & ~64'h3;
                if ($urandom_range(0, 9) == 0) req_len_dw = '0;
                else if ($urandom_range(0, 1) == 0) req_len_dw = 11'($urandom_range(1, 1024));
                else req_len_dw = 11'($urandom_range(1, 40));
            end
            tlp_ready = ($urandom_range(0, 3) != 0);
            cfg_mrrs  = 3'($urandom_range(0, 7));
            tag_free_valid = 1'b0;
            if ($urandom_range(0, 1) == 0) begin
                pick_busy(fv, ft);
                tag_free_valid = fv;
                tag_free       = ft;
            end
        end
        req_valid = 1'b0;
        tlp_ready = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk); #1;
            pick_busy(fv, ft);
            tag_free_valid = fv;
            tag_free       = ft;
            if (exp_q.size() == 0 && req_ready && !tlp_valid) break;
        end
        tag_free_valid = 1'b0;
        wait_idle();
        free_all();
        @(negedge clk);
        check("rand_err", 64'(err), 64'(m_err));

        // Reset while a request is mid-split
        cfg_mrrs  = 3'd0;
        tlp_ready = 1'b0;
        send_req(64'h5000, 11'd512);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_valid", 64'(tlp_valid), 64'd0);
        check("mid_rst_addr", tlp_addr, 64'd0);
        check("mid_rst_len", 64'(tlp_len_dw), 64'd0);
        check("mid_rst_tag", 64'(tlp_tag), 64'd0);
        check("mid_rst_last", 64'(tlp_last), 64'd0);
        check("mid_rst_outstanding", 64'(outstanding), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        tlp_ready = 1'b1;
        send_req(64'h6000, 11'd40);
        wait_idle();
        check("post_rst_outstanding", 64'(outstanding), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
